alu_packet_ctrl: RTL
====================

ALU_PACKET_CTRL -- requirements
Module: alu_packet_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 0, meaning the mid-packet idle cycles before abort (0 = timeout disabled).
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port s_axis_tdata  input  8  byte from UART receiver.
REQ-005 SHALL have port s_axis_tvalid  input  1  input byte valid.
REQ-006 SHALL have port s_axis_tready  output  1  input byte accepted when tvalid && tready.
REQ-007 SHALL have port m_axis_tdata  output  8  response byte to UART transmitter.
REQ-008 SHALL have port m_axis_tvalid  output  1  response byte valid.
REQ-009 SHALL have port m_axis_tready  input  1  transmitter accepts byte.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL parse a packet whose 4-byte header is: opcode, reserved, len_lo, len_hi, where len is the total packet bytes including the header.
REQ-012 SHALL use FSM states IDLE -> RSVD -> LEN_LO -> LEN_HI -> {ECHO | OPERAND | DRAIN} -> [MUL_WAIT] -> RESULT -> IDLE, advancing one state per accepted byte in the header states.
REQ-013 SHALL go from LEN_HI directly to IDLE, with no response, when len <= 4, except an arithmetic opcode, which goes to RESULT with result 0.
REQ-014 SHALL, for opcode 0xEC (echo), return payload bytes (len-4) verbatim in order, each appearing on m_axis the cycle after acceptance.
REQ-015 SHALL, in ECHO, hold s_axis_tready low while the output byte register is occupied and not being drained by m_axis_tready.
REQ-016 SHALL, for opcode 0x10 (add), treat the payload as 32-bit little-endian operands and sum them mod 2^32.
REQ-017 SHALL, for opcode 0x11 (mul), multiply the operands and keep the low 32 bits; the first operand loads the accumulator.
REQ-018 SHALL ignore trailing payload bytes that do not complete a 32-bit operand.
REQ-019 SHALL, in RESULT, emit the 32-bit result as 4 bytes, LSB first, holding tdata and tvalid stable until m_axis_tready.
REQ-020 SHALL consume (len-4) bytes for unknown opcodes in DRAIN, emit nothing, then return to IDLE.
REQ-021 SHALL keep s_axis_tready low in MUL_WAIT and RESULT.
REQ-022 SHALL, when TIMEOUT_CYCLES > 0 and no byte is accepted for TIMEOUT_CYCLES consecutive cycles in any receive state other than IDLE, return to IDLE and discard the partial packet.
REQ-023 SHALL never drop or duplicate a byte under arbitrary tvalid/tready stalls on either side.
REQ-024 SHALL use a 16-bit byte counter with no wrap; len = 0xFFFF is legal.

Reset
REQ-025 SHALL, on rst, asynchronously force state IDLE, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, busy=0, accumulator=0, and all counters to 0.
REQ-026 SHALL assert s_axis_tready=1 in IDLE from the first clock after rst deasserts.
REQ-027 SHALL, on rst mid-packet, discard all partial state, including any pending output byte.

Configuration
REQ-028 SHALL, with macro ALU_MUL_EN defined, support opcode 0x11 through an iterative multiplier (32 cycles per operand in MUL_WAIT).
REQ-029 SHALL, without ALU_MUL_EN, treat 0x11 as an unknown opcode (drained, no response) and omit the multiplier logic.

Structure
REQ-030 SHALL define the opcode enum (OP_ECHO=0xEC, OP_ADD=0x10, OP_MUL=0x11), the FSM state enum and HEADER_BYTES=4 in package alu_pkg.
REQ-031 SHALL place the shift-add multiplier in sub-module alu_mul_iter (start/done handshake, 32-bit a, b, low-32 product), instantiated only under ALU_MUL_EN.

Verification
REQ-032 SHALL check: echo packet EC 00 07 00 41 42 43 -> output 41 42 43, then IDLE.
REQ-033 SHALL check: add packet 10 00 0C 00 | 01 00 00 00 | FF FF FF FF -> output 00 00 00 00 (wrap).
REQ-034 SHALL check, with ALU_MUL_EN: 11 00 0C 00 | 03 00 00 00 | 05 00 00 00 -> 0F 00 00 00; without the macro -> no output, next packet handled normally.
REQ-035 SHALL check: unknown opcode 55 00 06 00 AA BB followed by an echo packet -> only the echo bytes are output.
REQ-036 SHALL check: random m_axis_tready stalls at 30% on a 64-byte echo -> exact byte stream, no loss.
REQ-037 SHALL check: rst pulsed after 2 payload bytes of an add packet -> no output, idle with s_axis_tready=1, next packet correct.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Opcodes, FSM states and header constants shared by alu_packet_ctrl.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [15:0] HEADER_BYTES = 16'd4;

    typedef enum logic [7:0] {
        OP_ADD  = 8'h10,
        OP_MUL  = 8'h11,
        OP_ECHO = 8'hEC
    } opcode_e;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RSVD     = 4'd1,
        LEN_LO   = 4'd2,
        LEN_HI   = 4'd3,
        ECHO     = 4'd4,
        OPERAND  = 4'd5,
        DRAIN    = 4'd6,
        MUL_WAIT = 4'd7,
        RESULT   = 4'd8
    } state_e;

    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_of = word[7:0];
            2'd1:    byte_of = word[15:8];
            2'd2:    byte_of = word[23:16];
            default: byte_of = word[31:24];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_iter
// Purpose  : Shift-add multiplier, low 32 bits of a*b, done pulses 32 cycles after start.
// Revision : 1.0
// ============================================================================
module alu_mul_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] product
);

    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [4:0]  r_cnt;
    logic        r_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                r_mcand  <= a;
                r_mplier <= b;
                r_cnt    <= '0;
                r_run    <= 1'b1;
                product  <= '0;
            end else if (r_run) begin
                if (r_mplier[0]) begin
                    product <= product + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    r_run <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_packet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_packet_ctrl
// Purpose  : Packet parser (echo / add / mul / drain) between UART RX and TX streams.
//            Define ALU_MUL_EN to build the mul opcode and its iterative multiplier.
// Revision : 1.0
// ============================================================================
module alu_packet_ctrl
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       busy
);

    state_e      r_state;
    state_e      w_next;

    logic        r_started;
    logic [7:0]  r_opcode;
    logic [7:0]  r_len_lo;
    logic [15:0] r_remaining;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_word;
    logic [31:0] r_acc;
    logic [1:0]  r_res_idx;

    logic        w_accept;
    logic [15:0] w_len;
    logic        w_last_byte;
    logic        w_word_done;
    logic [31:0] w_operand;
    logic        w_is_add;
    logic        w_is_mul;
    logic        w_is_arith;
    logic        w_out_free;
    logic        w_out_load;
    logic [7:0]  w_out_data;
    logic        w_timeout;
    logic        w_mul_first;
    logic        w_mul_chain;
    logic        w_mul_done;
    logic [31:0] w_mul_product;

    assign w_accept    = s_axis_tvalid && s_axis_tready;
    assign w_len       = {s_axis_tdata, r_len_lo};
    assign w_last_byte = (r_remaining == 16'd1);
    assign w_word_done = (r_byte_cnt == 2'd3);
    assign w_operand   = {s_axis_tdata, r_word};
    assign w_is_add    = (r_opcode == OP_ADD);
    assign w_is_arith  = w_is_add || w_is_mul;
    assign w_out_free  = !m_axis_tvalid || m_axis_tready;

`ifdef ALU_MUL_EN
    logic r_first;
    logic w_mul_start;

    assign w_is_mul    = (r_opcode == OP_MUL);
    assign w_mul_first = w_is_mul && r_first;
    assign w_mul_chain = w_is_mul && !r_first;
    assign w_mul_start = (r_state == OPERAND) && w_accept && w_word_done && w_mul_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first <= 1'b0;
        end else if (r_state == IDLE && w_accept) begin
            r_first <= 1'b1;
        end else if (r_state == OPERAND && w_accept && w_word_done && w_is_mul) begin
            r_first <= 1'b0;
        end
    end

    alu_mul_iter u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (r_acc),
        .b       (w_operand),
        .done    (w_mul_done),
        .product (w_mul_product)
    );
`else
    assign w_is_mul      = 1'b0;
    assign w_mul_first   = 1'b0;
    assign w_mul_chain   = 1'b0;
    assign w_mul_done    = 1'b0;
    assign w_mul_product = '0;
`endif

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam logic [31:0] c_LAST_IDLE = 32'(TIMEOUT_CYCLES - 1);
            logic [31:0] r_idle_cnt;
            logic        w_rx_state;

            assign w_rx_state = (r_state == RSVD) || (r_state == LEN_LO) || (r_state == LEN_HI) ||
                                (r_state == ECHO) || (r_state == OPERAND) || (r_state == DRAIN);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_idle_cnt <= '0;
                end else if (!w_rx_state || w_accept) begin
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 32'd1;
                end
            end

            assign w_timeout = w_rx_state && !w_accept && (r_idle_cnt == c_LAST_IDLE);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (w_accept) w_next = RSVD;
            RSVD:   if (w_accept) w_next = LEN_LO;
            LEN_LO: if (w_accept) w_next = LEN_HI;
            LEN_HI: begin
                if (w_accept) begin
                    // Header-only packets still answer with a zero result for arithmetic opcodes.
                    if (w_len <= HEADER_BYTES) begin
                        if (w_is_arith) w_next = RESULT;
                        else            w_next = IDLE;
                    end else if (r_opcode == OP_ECHO) begin
                        w_next = ECHO;
                    end else if (w_is_arith) begin
                        w_next = OPERAND;
                    end else begin
                        w_next = DRAIN;
                    end
                end
            end
            ECHO, DRAIN: if (w_accept && w_last_byte) w_next = IDLE;
            OPERAND: begin
                if (w_accept) begin
                    if (w_word_done && w_mul_chain) w_next = MUL_WAIT;
                    else if (w_last_byte)           w_next = RESULT;
                end
            end
            MUL_WAIT: begin
                if (w_mul_done) begin
                    if (r_remaining == 16'd0) w_next = RESULT;
                    else                      w_next = OPERAND;
                end
            end
            RESULT:  if (w_out_free && r_res_idx == 2'd3) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_timeout) begin
            w_next = IDLE;
        end
    end

    always_comb begin
        s_axis_tready = 1'b0;
        w_out_load    = 1'b0;
        w_out_data    = s_axis_tdata;
        busy          = (r_state != IDLE);
        case (r_state)
            IDLE, RSVD, LEN_LO, LEN_HI, OPERAND, DRAIN: begin
                s_axis_tready = r_started;
            end
            ECHO: begin
                s_axis_tready = r_started && w_out_free;
                w_out_load    = r_started && w_out_free && s_axis_tvalid;
            end
            RESULT: begin
                w_out_load = w_out_free;
                w_out_data = byte_of(r_acc, r_res_idx);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_started     <= 1'b0;
            r_opcode      <= '0;
            r_len_lo      <= '0;
            r_remaining   <= '0;
            r_byte_cnt    <= '0;
            r_word        <= '0;
            r_acc         <= '0;
            r_res_idx     <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            r_started <= 1'b1;

            if (w_out_load) begin
                m_axis_tdata  <= w_out_data;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (r_state == RESULT && w_out_free) begin
                r_res_idx <= r_res_idx + 2'd1;
            end

            if (w_accept) begin
                case (r_state)
                    IDLE: begin
                        r_opcode   <= s_axis_tdata;
                        r_acc      <= '0;
                        r_byte_cnt <= '0;
                        r_res_idx  <= '0;
                    end
                    LEN_LO: r_len_lo <= s_axis_tdata;
                    LEN_HI: begin
                        if (w_len > HEADER_BYTES) r_remaining <= w_len - HEADER_BYTES;
                        else                      r_remaining <= '0;
                    end
                    ECHO, DRAIN: r_remaining <= r_remaining - 16'd1;
                    OPERAND: begin
                        r_remaining <= r_remaining - 16'd1;
                        r_byte_cnt  <= r_byte_cnt + 2'd1;
                        r_word      <= {s_axis_tdata, r_word[23:8]};
                        if (w_word_done) begin
                            if (w_is_add)         r_acc <= r_acc + w_operand;
                            else if (w_mul_first) r_acc <= w_operand;
                        end
                    end
                    default: ;
                endcase
            end

            if (r_state == MUL_WAIT && w_mul_done) begin
                r_acc <= w_mul_product;
            end
        end
    end

endmodule
`default_nettype wire
